// File: rtl/relogio_pkg.sv
// Shared types, field limits and the wrap-step helper for the clock/stopwatch.
package relogio_pkg;

    typedef enum logic [1:0] {
        SEL_HOUR = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_SEC  = 2'd2,
        SEL_RUN  = 2'd3
    } sel_e;

    typedef enum logic {
        MODE_CLOCK     = 1'b0,
        MODE_STOPWATCH = 1'b1
    } mode_e;

    localparam logic [6:0] SEC_MAX   = 7'd59;
    localparam logic [6:0] MIN_MAX   = 7'd59;
    localparam logic [6:0] CENTI_MAX = 7'd99;

    // Step a field by +1 (up) or -1 (dn) wrapping within 0..max; both or neither
    // requested leaves the value unchanged.
    function automatic logic [6:0] wrap_step(input logic [6:0] val,
                                             input logic [6:0] max,
                                             input logic       up,
                                             input logic       dn);
        logic [6:0] res;
        res = val;
        if (up && !dn) begin
            res = (val >= max) ? 7'd0 : val + 7'd1;
        end else if (dn && !up) begin
            res = (val == 7'd0) ? max : val - 7'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/key_edge.sv
// Raw active-low push key -> two-flop synchroniser -> one-cycle press pulse.
module key_edge (
    input  logic clock,
    input  logic resetn,
    input  logic key_n,
    output logic pulse
);

    // [0],[1] synchronise, [2] holds the previous synchronised level
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    // Shift the raw key level through the synchroniser chain
    always_comb begin
        sync_d = {sync_q[1:0], key_n};
    end

    // Chain clears to 0 so an idle (high) key after reset never looks like a press
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign pulse = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/relogio_cronometro.sv
// 24 h time-of-day clock plus 1/100 s stopwatch with field edit and lap freeze.
module relogio_cronometro
    import relogio_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int TOD_HOURS   = 24,
    parameter int SW_MAX_MIN  = 99
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       mode_sw,
    input  logic [1:0] sel,
    input  logic       key_up_n,
    input  logic       key_dn_n,
    input  logic       key_ss_n,
    output logic [6:0] disp_hi,
    output logic [5:0] disp_mid,
    output logic [6:0] disp_lo,
    output logic       mode_led,
    output logic       running,
    output logic       lap,
    output logic       overflow
);

    localparam int PRESC_MAX = CLK_FREQ_HZ / 100 - 1;
    localparam int PRESC_W   = (PRESC_MAX > 0) ? $clog2(PRESC_MAX + 1) : 1;
    localparam logic [6:0] HOUR_MAX   = 7'(TOD_HOURS - 1);
    localparam logic [6:0] SW_MIN_TOP = 7'(SW_MAX_MIN);
    localparam logic [6:0] DIV_MAX    = 7'd99;

    logic up_p, dn_p, ss_p;

    logic               mode_s1_q, mode_s1_d, mode_s2_q, mode_s2_d;
    logic [1:0]         sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [6:0]         div_q, div_d;
    logic [6:0]         hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [6:0]         sw_min_q, sw_min_d, sw_sec_q, sw_sec_d, sw_centi_q, sw_centi_d;
    logic [6:0]         snap_min_q, snap_min_d, snap_sec_q, snap_sec_d, snap_centi_q, snap_centi_d;
    logic               running_q, running_d, lap_q, lap_d, ovf_q, ovf_d;

    mode_e mode_s;
    sel_e  sel_s;
    logic  tick_c, tick_s, edit, sw_mode, sw_ss, sw_up, sw_clr;

    key_edge u_key_up (.clock(clock), .resetn(resetn), .key_n(key_up_n), .pulse(up_p));
    key_edge u_key_dn (.clock(clock), .resetn(resetn), .key_n(key_dn_n), .pulse(dn_p));
    key_edge u_key_ss (.clock(clock), .resetn(resetn), .key_n(key_ss_n), .pulse(ss_p));

    assign mode_s  = mode_e'(mode_s2_q);
    assign sel_s   = sel_e'(sel_s2_q);
    assign tick_c  = (presc_q == PRESC_W'(PRESC_MAX));
    assign tick_s  = tick_c && (div_q == DIV_MAX);
    assign edit    = (mode_s == MODE_CLOCK) && (sel_s != SEL_RUN);
    assign sw_mode = (mode_s == MODE_STOPWATCH);
    assign sw_ss   = sw_mode & ss_p;
    assign sw_up   = sw_mode & up_p;
    // start/stop takes priority over clear, and clear only applies when stopped
    assign sw_clr  = sw_mode & dn_p & ~ss_p & ~running_q;

    // Switch synchronisers and the centisecond / second prescaler chain
    always_comb begin
        mode_s1_d = mode_sw;
        mode_s2_d = mode_s1_q;
        sel_s1_d  = sel;
        sel_s2_d  = sel_s1_q;
        presc_d   = tick_c ? '0 : presc_q + PRESC_W'(1);
        div_d     = div_q;
        if (tick_c) begin
            div_d = wrap_step(div_q, DIV_MAX, 1'b1, 1'b0);
        end
    end

    // Time of day: field edit while a field is selected, otherwise ripple-carry count
    always_comb begin
        hour_d = hour_q;
        min_d  = min_q;
        sec_d  = sec_q;
        if (edit) begin
            case (sel_s)
                SEL_HOUR: hour_d = wrap_step(hour_q, HOUR_MAX, up_p, dn_p);
                SEL_MIN:  min_d  = wrap_step(min_q, MIN_MAX, up_p, dn_p);
                SEL_SEC:  sec_d  = ss_p ? 7'd0 : wrap_step(sec_q, SEC_MAX, up_p, dn_p);
                default:  ;
            endcase
        end else if (tick_s) begin
            sec_d = wrap_step(sec_q, SEC_MAX, 1'b1, 1'b0);
            if (sec_q == SEC_MAX) begin
                min_d = wrap_step(min_q, MIN_MAX, 1'b1, 1'b0);
                if (min_q == MIN_MAX) begin
                    hour_d = wrap_step(hour_q, HOUR_MAX, 1'b1, 1'b0);
                end
            end
        end
    end

    // Stopwatch: run/lap toggles, clear when stopped, count and sticky wrap flag
    always_comb begin
        running_d    = running_q ^ sw_ss;
        lap_d        = lap_q ^ sw_up;
        ovf_d        = ovf_q;
        sw_min_d     = sw_min_q;
        sw_sec_d     = sw_sec_q;
        sw_centi_d   = sw_centi_q;
        snap_min_d   = snap_min_q;
        snap_sec_d   = snap_sec_q;
        snap_centi_d = snap_centi_q;
        if (sw_up && !lap_q) begin
            snap_min_d   = sw_min_q;
            snap_sec_d   = sw_sec_q;
            snap_centi_d = sw_centi_q;
        end
        if (sw_clr) begin
            lap_d      = 1'b0;
            ovf_d      = 1'b0;
            sw_min_d   = 7'd0;
            sw_sec_d   = 7'd0;
            sw_centi_d = 7'd0;
        end else if (running_q && tick_c) begin
            sw_centi_d = wrap_step(sw_centi_q, CENTI_MAX, 1'b1, 1'b0);
            if (sw_centi_q == CENTI_MAX) begin
                sw_sec_d = wrap_step(sw_sec_q, SEC_MAX, 1'b1, 1'b0);
                if (sw_sec_q == SEC_MAX) begin
                    sw_min_d = wrap_step(sw_min_q, SW_MIN_TOP, 1'b1, 1'b0);
                    if (sw_min_q >= SW_MIN_TOP) begin
                        ovf_d = 1'b1;
                    end
                end
            end
        end
    end

    // All state registers; reset clears everything
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mode_s1_q    <= 1'b0;
            mode_s2_q    <= 1'b0;
            sel_s1_q     <= 2'd0;
            sel_s2_q     <= 2'd0;
            presc_q      <= '0;
            div_q        <= 7'd0;
            hour_q       <= 7'd0;
            min_q        <= 7'd0;
            sec_q        <= 7'd0;
            sw_min_q     <= 7'd0;
            sw_sec_q     <= 7'd0;
            sw_centi_q   <= 7'd0;
            snap_min_q   <= 7'd0;
            snap_sec_q   <= 7'd0;
            snap_centi_q <= 7'd0;
            running_q    <= 1'b0;
            lap_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            mode_s1_q    <= mode_s1_d;
            mode_s2_q    <= mode_s2_d;
            sel_s1_q     <= sel_s1_d;
            sel_s2_q     <= sel_s2_d;
            presc_q      <= presc_d;
            div_q        <= div_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            sw_min_q     <= sw_min_d;
            sw_sec_q     <= sw_sec_d;
            sw_centi_q   <= sw_centi_d;
            snap_min_q   <= snap_min_d;
            snap_sec_q   <= snap_sec_d;
            snap_centi_q <= snap_centi_d;
            running_q    <= running_d;
            lap_q        <= lap_d;
            ovf_q        <= ovf_d;
        end
    end

    // Display mux: clock fields, live stopwatch, or the lap snapshot
    always_comb begin
        disp_hi  = hour_q;
        disp_mid = min_q[5:0];
        disp_lo  = sec_q;
        if (mode_s == MODE_STOPWATCH) begin
            if (lap_q) begin
                disp_hi  = snap_min_q;
                disp_mid = snap_sec_q[5:0];
                disp_lo  = snap_centi_q;
            end else begin
                disp_hi  = sw_min_q;
                disp_mid = sw_sec_q[5:0];
                disp_lo  = sw_centi_q;
            end
        end
    end

    assign mode_led = mode_s2_q;
    assign running  = running_q;
    assign lap      = lap_q;
    assign overflow = ovf_q;

endmodule

// File: doc/relogio_cronometro.md
Name: relogio_cronometro

Overview:
Parametrised successor to the board clock block.
- Combines a 24 h time-of-day clock and a 1/100 s stopwatch, both running continuously in the background.
- Provides per-field set with increment/decrement and a lap-freeze display.
- Sits between the DE2 switches/push-keys and the 7-segment decoder stage.
- Outputs are binary fields; BCD conversion happens downstream.

Parameters:
- CLK_FREQ_HZ, 50_000_000: input clock frequency. Must be a multiple of 100 and at least 100.
- TOD_HOURS, 24: time-of-day hour modulus, legal range 2..100.
- SW_MAX_MIN, 99: stopwatch minute field maximum before wrap, legal range 1..99.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- mode_sw  in  1  0 = clock mode, 1 = stopwatch mode (raw switch)
- sel  in  2  clock-mode field select: 0 = hours, 1 = minutes, 2 = seconds, 3 = run (raw switches)
- key_up_n  in  1  push key, active-low, raw
- key_dn_n  in  1  push key, active-low, raw
- key_ss_n  in  1  push key, active-low, raw
- disp_hi  out  7  hours (clock mode) / minutes (stopwatch mode)
- disp_mid  out  6  minutes / seconds
- disp_lo  out  7  seconds / centiseconds
- mode_led  out  1  synchronised mode_sw
- running  out  1  stopwatch counting
- lap  out  1  stopwatch display frozen
- overflow  out  1  sticky stopwatch wrap flag

Behaviour:
- Reset: every counter, prescaler, flag and output goes to 0 asynchronously. After release, the first tick occurs after a full prescale period.
- Input synchronisation:
  - mode_sw and sel pass through two-flop synchronisers.
  - Each key passes through key_edge: a two-flop synchroniser plus falling-edge detect, producing a one-cycle pulse.
  - Latency: a key falling edge produces its effect on the 3rd rising clock edge after the edge. A held key produces exactly one pulse.
- Prescaler:
  - Counts 0..CLK_FREQ_HZ/100-1. tick_c pulses at the terminal count.
  - A /100 counter driven by tick_c produces tick_s.
  - The prescaler runs whenever not in reset.
- Time-of-day counter (sec 0..59, min 0..59, hour 0..TOD_HOURS-1):
  - Advances on tick_s with ripple carry; 23:59:59 -> 00:00:00.
  - Advances in both modes, except when mode=0 and sel!=3 (edit): the counter is frozen and ticks are discarded.
  - Edit, mode=0 and sel in 0..2:
    - up pulse increments the selected field, down pulse decrements it.
    - Wrap within the field (hours 23->0, 0->23; min/sec 59->0, 0->59). No carry into neighbouring fields.
    - up and down in the same cycle: no change.
    - ss pulse with sel=2 clears seconds; otherwise ss is ignored in clock mode.
- Stopwatch (centi 0..99, sec 0..59, min 0..SW_MAX_MIN):
  - Advances on tick_c while running=1, in either mode.
  - At SW_MAX_MIN:59.99 the next tick wraps to 00:00.00 and sets overflow.
- Stopwatch keys, honoured only when mode=1:
  - ss pulse toggles running.
  - up pulse toggles lap. While lap=1, the display shows the snapshot captured at the lap-set pulse; counting continues underneath.
  - dn pulse while running=0 clears the counters, lap and overflow. dn pulse while running=1 is ignored.
  - ss and dn in the same cycle: ss wins; clear is ignored.
- Key pulses in the non-owning mode have no effect.
- Switching mode never stops either counter.
- Display mux: combinational from the registered counter and snapshot values, selected by synchronised mode.
  - mode=0 shows hour/min/sec.
  - mode=1 shows min/sec/centi, or the snapshot when lap=1.
- Tick coincident with an edit pulse: in edit the tick is discarded, so only the edit applies.
- Tick coincident with a stopwatch clear: clear wins and the result is 00:00.00.
- Reset mid-operation: everything is lost and no state is retained.

Decomposition:
- Package relogio_pkg:
  - Field-select enum (SEL_HOUR, SEL_MIN, SEL_SEC, SEL_RUN).
  - Mode enum (MODE_CLOCK, MODE_STOPWATCH).
  - Constants SEC_MAX=59, MIN_MAX=59, CENTI_MAX=99.
  - Helper function for wrap-increment/decrement by modulus.
- Sub-module key_edge: synchroniser plus falling-edge pulse, instantiated three times.

Test Plan:
All scenarios use CLK_FREQ_HZ=100, so tick_c fires every cycle and tick_s every 100 cycles.
1. Reset release, mode=0, sel=3, run 8640000 cycles -> time reads 23:59:59 at cycle 8639999, then 00:00:00; sample 100 cycles after reset gives 00:00:01.
2. Edit: sel=0, hours=23, press key_up_n -> hours=0 exactly 3 cycles after the falling edge, minutes/seconds unchanged, no seconds advance while sel=0; press key_dn_n -> 23; hold key_up_n low 50 cycles -> only one increment.
3. Stopwatch: mode=1, press ss, wait 6150 cycles, press ss -> display 01:01.50 (±3 cycles of sync latency); press dn -> 00:00.00, running=0.
4. Lap: running, press up at 00:02.00 -> display holds 00:02.00 for 300 cycles while lap=1; press up -> display shows 00:05.00.
5. Overflow: SW_MAX_MIN=1, run 12000 cycles -> wraps to 00:00.00, overflow=1; dn while running is ignored; stop then dn clears overflow.
6. Reset mid-run: resetn low asynchronously at 00:03.47 -> all outputs 0 before the next clock edge; counting after release restarts from 0.
